// File: rtl/ahb_s2m_mux.sv
// AHB slave-to-master return mux: latches the data-phase slave select, routes the
// selected slave's response to the master, and hosts the default slave for unmapped transfers.
module ahb_s2m_mux #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned HSLV_NUM     = 5,
    parameter int unsigned HSLV_LEN     = 32,
    parameter int unsigned ERRCNT_WIDTH = 16
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic [HSLV_NUM-1:0]     hsel_i,
    input  logic                    hsel_vld_i,
    input  logic [1:0]              htrans_i,
    input  logic [DATA_WIDTH-1:0]   hrdata_i    [0:HSLV_LEN-1],
    input  logic                    hreadyout_i [0:HSLV_LEN-1],
    input  logic                    hresp_i     [0:HSLV_LEN-1],
    output logic [DATA_WIDTH-1:0]   hrdata_o,
    output logic                    hready_o,
    output logic                    hresp_o,
    output logic [HSLV_NUM-1:0]     dsel_o,
    output logic [ERRCNT_WIDTH-1:0] err_cnt_o
);

    localparam int unsigned IDX_W = (HSLV_LEN > 1) ? $clog2(HSLV_LEN) : 1;
    localparam int unsigned CMP_W = HSLV_NUM + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLV  = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t            state;
    logic              mapped;
    logic              active;
    logic [IDX_W-1:0]  dsel_idx;

    // Out-of-range indices are folded into "unmapped" so dsel_o never leaves the port range.
    assign mapped   = hsel_vld_i && (CMP_W'(hsel_i) < CMP_W'(HSLV_LEN));
    assign active   = htrans_i inside {2'b10, 2'b11};
    assign dsel_idx = IDX_W'(dsel_o);

    // State, data-phase select and saturating error counter.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= ST_IDLE;
            dsel_o    <= '0;
            err_cnt_o <= '0;
        end else if (state == ST_ERR1) begin
            state <= ST_ERR2;
        end else if (hready_o) begin
            if (mapped) begin
                state  <= ST_SLV;
                dsel_o <= hsel_i;
            end else if (active) begin
                state <= ST_ERR1;
                if (err_cnt_o != '1) begin
                    err_cnt_o <= err_cnt_o + ERRCNT_WIDTH'(1);
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    // Response routing; default slave answers OKAY/ERROR with zero read data.
    always_comb begin
        hrdata_o = '0;
        hready_o = 1'b1;
        hresp_o  = 1'b0;
        case (state)
            ST_SLV: begin
                hrdata_o = hrdata_i[dsel_idx];
                hready_o = hreadyout_i[dsel_idx];
                hresp_o  = hresp_i[dsel_idx];
            end
            ST_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = 1'b1;
            end
            ST_ERR2: begin
                hresp_o  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_s2m_mux.sv
// Randomized scoreboard bench for ahb_s2m_mux: a transaction-level model predicts every
// data-phase cycle, and a negedge monitor compares the DUT against the queued predictions.
module tb_ahb_s2m_mux;

    localparam int unsigned DW  = 32;
    localparam int unsigned NUM = 5;
    localparam int unsigned LEN = 8;
    localparam int unsigned CW  = 8;

    typedef struct {
        logic        vld;
        logic [4:0]  sel;
        logic [1:0]  trans;
        int          waits;
        logic [31:0] data;
        logic        resp;
    } txn_t;

    typedef struct packed {
        logic        hready;
        logic        hresp;
        logic [31:0] rdata;
        logic [4:0]  dsel;
        logic [7:0]  cnt;
    } exp_t;

    logic            hclk = 1'b0;
    logic            hreset;
    logic [NUM-1:0]  hsel;
    logic            hsel_vld;
    logic [1:0]      htrans;
    logic [DW-1:0]   hrdata_s    [0:LEN-1];
    logic            hreadyout_s [0:LEN-1];
    logic            hresp_s     [0:LEN-1];
    logic [DW-1:0]   hrdata;
    logic            hready;
    logic            hresp;
    logic [NUM-1:0]  dsel;
    logic [CW-1:0]   err_cnt;

    ahb_s2m_mux #(
        .DATA_WIDTH  (DW),
        .HSLV_NUM    (NUM),
        .HSLV_LEN    (LEN),
        .ERRCNT_WIDTH(CW)
    ) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .hsel_i     (hsel),
        .hsel_vld_i (hsel_vld),
        .htrans_i   (htrans),
        .hrdata_i   (hrdata_s),
        .hreadyout_i(hreadyout_s),
        .hresp_i    (hresp_s),
        .hrdata_o   (hrdata),
        .hready_o   (hready),
        .hresp_o    (hresp),
        .dsel_o     (dsel),
        .err_cnt_o  (err_cnt)
    );

    always #5 hclk = ~hclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_cyc = 0;
    exp_t        sb[$];
    txn_t        txns[$];
    logic [4:0]  m_dsel = 5'd0;
    logic [7:0]  m_cnt  = 8'd0;
    exp_t        mon_exp;
    exp_t        mon_act;

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b resp=%b data=%h dsel=%0d cnt=%0d, expected rdy=%b resp=%b data=%h dsel=%0d cnt=%0d",
                     name, act.hready, act.hresp, act.rdata, act.dsel, act.cnt,
                     exp.hready, exp.hresp, exp.rdata, exp.dsel, exp.cnt);
        end
    endtask

    function automatic logic is_mapped(input txn_t t);
        return t.vld && (t.sel < 5'(LEN));
    endfunction

    function automatic int phase_len(input txn_t t);
        if (is_mapped(t)) return t.waits + 1;
        return t.trans[1] ? 2 : 1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? 8'hFF : c + 8'd1;
    endfunction

    // Reference model: the full data-phase response sequence of one accepted transfer.
    task automatic push_expect(input txn_t t);
        if (is_mapped(t)) begin
            m_dsel = t.sel;
            for (int k = 0; k <= t.waits; k++) begin
                sb.push_back('{hready: (k == t.waits), hresp: t.resp,
                               rdata: (k == t.waits) ? t.data : ~t.data,
                               dsel: m_dsel, cnt: m_cnt});
            end
        end else if (t.trans[1]) begin
            m_cnt = sat_inc(m_cnt);
            sb.push_back('{hready: 1'b0, hresp: 1'b1, rdata: 32'h0, dsel: m_dsel, cnt: m_cnt});
            sb.push_back('{hready: 1'b1, hresp: 1'b1, rdata: 32'h0, dsel: m_dsel, cnt: m_cnt});
        end else begin
            sb.push_back('{hready: 1'b1, hresp: 1'b0, rdata: 32'h0, dsel: m_dsel, cnt: m_cnt});
        end
    endtask

    // Slave models: all slaves toggle noise; the data-phase slave plays its scripted response.
    task automatic drive_slaves(input logic on, input txn_t t, input int k);
        logic [2:0] si;
        for (int i = 0; i < LEN; i++) begin
            hreadyout_s[i] = 1'($urandom_range(0, 1));
            hrdata_s[i]    = $urandom;
            hresp_s[i]     = 1'($urandom_range(0, 1));
        end
        if (on && is_mapped(t)) begin
            si = t.sel[2:0];
            hreadyout_s[si] = (k == t.waits);
            hrdata_s[si]    = (k == t.waits) ? t.data : ~t.data;
            hresp_s[si]     = t.resp;
        end
    endtask

    function automatic txn_t mk(input logic vld, input logic [4:0] sel, input logic [1:0] trans,
                                input int waits, input logic [31:0] data, input logic resp);
        txn_t t;
        t.vld = vld; t.sel = sel; t.trans = trans; t.waits = waits; t.data = data; t.resp = resp;
        return t;
    endfunction

    function automatic txn_t rand_txn(input logic force_err);
        txn_t t;
        int   r;
        r = force_err ? 5 : $urandom_range(0, 9);
        t.vld   = 1'($urandom_range(0, 1));
        t.sel   = t.vld ? 5'($urandom_range(LEN, 31)) : 5'($urandom_range(0, 31));
        t.trans = 2'($urandom_range(0, 3));
        t.waits = 0;
        t.data  = $urandom;
        t.resp  = 1'b0;
        if (r < 5) begin
            t.vld   = 1'b1;
            t.sel   = 5'($urandom_range(0, LEN - 1));
            t.waits = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            t.resp  = ($urandom_range(0, 7) == 0);
        end else if (r < 7) begin
            t.trans[1] = 1'b1;
        end else begin
            t.trans[1] = 1'b0;
        end
        return t;
    endfunction

    // Monitor: compare every cycle that has a queued prediction.
    always @(negedge hclk) begin
        if (!hreset && sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_act = {hready, hresp, hrdata, dsel, err_cnt};
            check($sformatf("cycle%0d", n_cyc), mon_act, mon_exp);
        end
        n_cyc++;
    end

    initial begin
        txn_t d;
        txn_t a;
        logic d_on;
        int   dlen;
        int   k;
        int   idx;
        exp_t e;

        hreset   = 1'b1;
        hsel     = '0;
        hsel_vld = 1'b0;
        htrans   = 2'b00;
        d        = mk(1'b0, 5'd0, 2'b00, 0, 32'h0, 1'b0);
        drive_slaves(1'b0, d, 0);
        repeat (3) @(posedge hclk);
        #1;
        check("reset_state", {hready, hresp, hrdata, dsel, err_cnt}, '0 | {1'b1, 46'h0});

        txns.push_back(mk(1'b1, 5'd3,  2'b10, 2, 32'hDEADBEEF, 1'b0));
        txns.push_back(mk(1'b1, 5'd1,  2'b10, 0, 32'h00000011, 1'b0));
        txns.push_back(mk(1'b1, 5'd2,  2'b11, 0, 32'h00000022, 1'b0));
        txns.push_back(mk(1'b0, 5'd4,  2'b10, 0, 32'h0,        1'b0));
        txns.push_back(mk(1'b0, 5'd5,  2'b00, 0, 32'h0,        1'b0));
        txns.push_back(mk(1'b1, 5'd31, 2'b10, 0, 32'h0,        1'b0));
        txns.push_back(mk(1'b1, 5'd6,  2'b10, 1, 32'hCAFEF00D, 1'b1));
        txns.push_back(mk(1'b0, 5'd0,  2'b10, 0, 32'h0,        1'b0));
        txns.push_back(mk(1'b1, 5'd7,  2'b01, 0, 32'h12345678, 1'b0));
        for (int i = 0; i < 300; i++) txns.push_back(rand_txn(1'b0));
        for (int i = 0; i < 260; i++) txns.push_back(rand_txn(1'b1));
        for (int i = 0; i < 60;  i++) txns.push_back(rand_txn(1'b0));

        hreset = 1'b0;
        sb.push_back('{hready: 1'b1, hresp: 1'b0, rdata: 32'h0, dsel: 5'd0, cnt: 8'd0});
        d_on = 1'b0;
        dlen = 1;
        k    = 0;
        idx  = 0;
        while (idx < txns.size()) begin
            a        = txns[idx];
            hsel     = a.sel;
            hsel_vld = a.vld;
            htrans   = a.trans;
            drive_slaves(d_on, d, k);
            @(posedge hclk);
            if (k == dlen - 1) begin
                push_expect(a);
                d    = a;
                d_on = 1'b1;
                dlen = phase_len(a);
                k    = 0;
                idx++;
            end else begin
                k++;
            end
            #1;
        end

        // Finish the last data phase behind an unchecked unmapped IDLE.
        hsel     = '0;
        hsel_vld = 1'b0;
        htrans   = 2'b00;
        while (k < dlen) begin
            drive_slaves(d_on, d, k);
            @(posedge hclk);
            k++;
            #1;
        end
        drive_slaves(1'b0, d, 0);
        repeat (2) @(posedge hclk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left, expected 0", sb.size());
        end

        // One more unmapped NONSEQ on a saturated counter, then reset inside ERR1.
        htrans = 2'b10;
        m_cnt  = sat_inc(m_cnt);
        @(posedge hclk);
        #1;
        htrans = 2'b00;
        e = '{hready: 1'b0, hresp: 1'b1, rdata: 32'h0, dsel: m_dsel, cnt: m_cnt};
        check("err1_saturated", {hready, hresp, hrdata, dsel, err_cnt}, e);
        #2 hreset = 1'b1;
        #1;
        e = '{hready: 1'b1, hresp: 1'b0, rdata: 32'h0, dsel: 5'd0, cnt: 8'd0};
        check("async_reset_in_err1", {hready, hresp, hrdata, dsel, err_cnt}, e);
        @(posedge hclk);
        #1 hreset = 1'b0;
        @(posedge hclk);
        #1;
        check("idle_after_reset", {hready, hresp, hrdata, dsel, err_cnt}, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_s2m_mux.md
Name: ahb_s2m_mux

Overview:
- Response-side return path of the AHB interconnect. Captures the decoded slave select at each accepted address phase and holds it for the data phase.
- Routes the selected slave's hrdata/hreadyout/hresp back to the master side as the bus hready.
- Contains the built-in default slave: zero-wait OKAY for unmapped IDLE/BUSY transfers, and the two-cycle ERROR response for unmapped NONSEQ/SEQ transfers.

Parameters:
- DATA_WIDTH, 32, read data width.
- HSLV_NUM, 5, width of the encoded slave index.
- HSLV_LEN, 32, number of slave ports; must be ≤ 2^HSLV_NUM.
- ERRCNT_WIDTH, 16, width of the saturating default-slave error counter.

Ports:
- hclk  input  1  bus clock.
- hreset  input  1  asynchronous, active-high reset.
- hsel_i  input  HSLV_NUM  encoded slave index decoded from the current address-phase haddr.
- hsel_vld_i  input  1  1 = address maps to a slave; 0 = unmapped.
- htrans_i  input  2  current address-phase htrans (output of the m2s mux).
- hrdata_i  input  DATA_WIDTH x [0:HSLV_LEN-1]  slave read data.
- hreadyout_i  input  1 x [0:HSLV_LEN-1]  slave hreadyout.
- hresp_i  input  1 x [0:HSLV_LEN-1]  slave hresp (0 = OKAY, 1 = ERROR).
- hrdata_o  output  DATA_WIDTH  read data to the master.
- hready_o  output  1  bus hready; also fans back to every slave's hready input.
- hresp_o  output  1  response to the master.
- dsel_o  output  HSLV_NUM  registered data-phase slave index.
- err_cnt_o  output  ERRCNT_WIDTH  count of default-slave ERROR responses.

Behaviour:

Clock and reset:
- Single clock domain, hclk.
- hreset asynchronous, active-high.
- Reset values: state = IDLE, dsel_o = 0, err_cnt_o = 0.
- Resulting outputs in reset: hready_o = 1, hresp_o = 0, hrdata_o = 0.

Address-phase acceptance:
- An address phase is accepted on any rising hclk edge where hready_o = 1.
- On acceptance, next state is chosen by priority:
  - hsel_vld_i = 1 and hsel_i < HSLV_LEN → SLV, with dsel_o ← hsel_i.
  - Otherwise, if htrans_i[1] = 1 (NONSEQ/SEQ) → ERR1.
  - Otherwise → IDLE.
- hsel_i ≥ HSLV_LEN with hsel_vld_i = 1 is treated as unmapped.
- dsel_o updates only when entering SLV; in all other states it holds its last value.

States and outputs (all outputs are combinational from registered state):
- IDLE: hready_o = 1, hresp_o = 0, hrdata_o = 0.
- SLV: hrdata_o = hrdata_i[dsel_o], hready_o = hreadyout_i[dsel_o], hresp_o = hresp_i[dsel_o].
  - The mux is pure passthrough; slave wait states and slave two-cycle errors propagate unchanged.
  - Remains in SLV while hreadyout_i[dsel_o] = 0.
- ERR1: hready_o = 0, hresp_o = 1, hrdata_o = 0.
  - Next state is always ERR2; the address phase is not accepted.
  - err_cnt_o increments on the edge entering ERR1 and saturates at all-ones (no wrap).
- ERR2: hready_o = 1, hresp_o = 1, hrdata_o = 0.
  - Accepts the next address phase using the acceptance rule above.
  - ERR2 → ERR1 is allowed, giving back-to-back errors.

Latency and timing:
- Response path latency is 0 cycles from slave to master (combinational).
- The data-phase select lags the address phase by exactly one accepted transfer.

Boundary conditions:
- Unmapped IDLE/BUSY: zero-wait OKAY via IDLE state; counter unchanged.
- Slave switch (slave A data phase coincident with slave B address phase): A's response is routed until A's hreadyout = 1; dsel_o switches to B on that same edge.
- Reset asserted mid-ERR1 or mid-SLV wait: immediate return to IDLE; outputs take reset values asynchronously; counter cleared.
- No X propagation: out-of-range dsel_o is unreachable by construction.

Test Plan:
1. Reset → hready_o = 1, hresp_o = 0, hrdata_o = 0, err_cnt_o = 0, dsel_o = 0.
2. NONSEQ read to slave 3, hreadyout_i[3] low for 2 cycles, hrdata_i[3] = 0xDEADBEEF → hready_o = 0,0,1; on the third cycle hrdata_o = 0xDEADBEEF, hresp_o = 0, dsel_o = 3.
3. Pipelined slave 1 then slave 2, zero-wait, with hrdata_i[1] = 0x11, hrdata_i[2] = 0x22 → data phases return 0x11 then 0x22 on consecutive cycles; dsel_o sequence 1, 2.
4. Unmapped NONSEQ (hsel_vld_i = 0, htrans_i = 2'b10) → ERR1 (hready_o = 0, hresp_o = 1), then ERR2 (hready_o = 1, hresp_o = 1); err_cnt_o 0 → 1.
5. Unmapped IDLE (htrans_i = 2'b00), and hsel_vld_i = 1 with hsel_i = 31 when HSLV_LEN = 8 and NONSEQ:
   - Unmapped IDLE → zero-wait OKAY, err_cnt_o unchanged.
   - Out-of-range index with NONSEQ → two-cycle ERROR, err_cnt_o +1.
6. Preload err_cnt_o to 0xFFFF via repeated errors, then issue one more unmapped NONSEQ → err_cnt_o stays 0xFFFF. Assert hreset during ERR1 → IDLE, hready_o = 1, err_cnt_o = 0.
